// File: rtl/ldpc_dvb_enc_pp_ctrl.sv
// Ping-pong bank controller between the LDPC frame writer and the encoder core.
// Define LDPC_DVB_ENC_PP_CTRL_ERR_EN to add the sticky oerr {release_err, write_err} port.
module ldpc_dvb_enc_pp_ctrl #(
  parameter int pCTX_W = 16
) (
  input  logic              iclk,
  input  logic              ireset_n,
  input  logic              iclkena,
  input  logic              iwdone,
  input  logic [pCTX_W-1:0] iwctx,
  output logic              owrdy,
  output logic              owbank,
  input  logic              istart,
  input  logic              irelease,
  output logic              obuf_full,
  output logic              orbank,
  output logic [pCTX_W-1:0] orctx,
  output logic [1:0]        ocount
`ifdef LDPC_DVB_ENC_PP_CTRL_ERR_EN
  ,
  output logic [1:0]        oerr
`endif
);

  // state   | meaning
  // FREE    | bank empty, writer may fill it
  // FILLED  | frame complete, waiting for the encoder
  // BUSY    | encoder is reading the bank
  localparam logic [1:0] FREE   = 2'b00;
  localparam logic [1:0] FILLED = 2'b01;
  localparam logic [1:0] BUSY   = 2'b10;

  logic [1:0]        bank_st_q [2];
  logic [1:0]        bank_st_d [2];
  logic [pCTX_W-1:0] ctx_q [2];
  logic [pCTX_W-1:0] ctx_d [2];
  logic              wptr_q, wptr_d;
  logic              rptr_q, rptr_d;

  logic wr_ok, start_ok, rel_ok;

  // Each event needs a distinct pre-edge bank state, so accepted events never
  // collide on one bank and can all be applied in the same cycle.
  assign wr_ok    = iwdone   && (bank_st_q[wptr_q] == FREE);
  assign start_ok = istart   && (bank_st_q[rptr_q] == FILLED);
  assign rel_ok   = irelease && (bank_st_q[rptr_q] == BUSY);

  always_comb begin
    bank_st_d = bank_st_q;
    ctx_d     = ctx_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    if (wr_ok) begin
      bank_st_d[wptr_q] = FILLED;
      ctx_d[wptr_q]     = iwctx;
      wptr_d            = ~wptr_q;
    end
    if (start_ok) begin
      bank_st_d[rptr_q] = BUSY;
    end
    if (rel_ok) begin
      bank_st_d[rptr_q] = FREE;
      rptr_d            = ~rptr_q;
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      bank_st_q[0] <= FREE;
      bank_st_q[1] <= FREE;
      ctx_q[0]     <= '0;
      ctx_q[1]     <= '0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
    end else if (iclkena) begin
      bank_st_q <= bank_st_d;
      ctx_q     <= ctx_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

`ifdef LDPC_DVB_ENC_PP_CTRL_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (iwdone && !wr_ok) err_d[0] = 1'b1;
    if (irelease && !rel_ok) err_d[1] = 1'b1;
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      err_q <= 2'b00;
    end else if (iclkena) begin
      err_q <= err_d;
    end
  end

  assign oerr = err_q;
`endif

  assign owbank    = wptr_q;
  assign orbank    = rptr_q;
  assign owrdy     = (bank_st_q[wptr_q] == FREE);
  assign obuf_full = (bank_st_q[rptr_q] == FILLED);
  assign orctx     = ctx_q[rptr_q];
  assign ocount    = {1'b0, (bank_st_q[0] != FREE)} + {1'b0, (bank_st_q[1] != FREE)};

endmodule
